poly_tone_mixer: RTL

- Polyphonic tone synthesiser and mixer between the codec controller's sample FIFOs and the microphone path.
- Generates NUM_VOICES independent DDS voices, each with a selectable note, waveform and gain, and sums them.
- Optionally adds the captured mic sample and saturates the result to the sample width.
- Runs a registered read→mix→write handshake, one output sample per input sample.

---
 rtl/poly_tone_pkg.sv | 54 +++++
 rtl/tone_voice.sv | 53 +++++
 rtl/poly_tone_mixer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/poly_tone_pkg.sv
// Shared types, note tuning table and saturation helper for the poly tone mixer.
package poly_tone_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE     = 2'd0,
    WAVE_SAW        = 2'd1,
    WAVE_TRI        = 2'd2,
    WAVE_SQUARE_ALT = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MIX   = 2'd1,
    ST_SAT   = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam logic [3:0] NOTE_SILENT_LO = 4'd0;
  localparam logic [3:0] NOTE_SILENT_HI = 4'd15;
  localparam int         TUNE_W         = 32;

  function automatic logic note_is_silent(input logic [3:0] note);
    return (note == NOTE_SILENT_LO) || (note == NOTE_SILENT_HI);
  endfunction

  // Notes 1..7 are C4..B4; 8..14 repeat the same row one octave up.
  function automatic logic [TUNE_W-1:0] note_tuning(input logic [3:0] note);
    logic [TUNE_W-1:0] base;
    case (note)
      4'd1,  4'd8:  base = 32'd22474;
      4'd2,  4'd9:  base = 32'd25225;
      4'd3,  4'd10: base = 32'd28315;
      4'd4,  4'd11: base = 32'd29999;
      4'd5,  4'd12: base = 32'd33673;
      4'd6,  4'd13: base = 32'd37796;
      4'd7,  4'd14: base = 32'd42424;
      default:      base = '0;
    endcase
    return (note >= 4'd8) ? (base << 1) : base;
  endfunction

  // Clamp a sign-extended accumulator to the signed range of a w-bit sample.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] acc,
                                                  input int                 w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (acc > hi)      return hi;
    else if (acc < lo) return lo;
    else               return acc;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One DDS voice: phase accumulator, waveform shaping and gain, producing a signed sample.
module tone_voice
  import poly_tone_pkg::*;
#(
  parameter int SAMPLE_W  = 32,
  parameter int PHASE_W   = 32,
  parameter int AMP_SHIFT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          note,
  input  logic [1:0]          wave,
  input  logic [2:0]          gain,
  output logic [SAMPLE_W-1:0] sample
);

  logic                       silent;
  logic [PHASE_W-1:0]         phase_q;
  logic [PHASE_W-1:0]         phase_d;
  logic [15:0]                p;
  logic [14:0]                fold;
  logic [15:0]                w;
  logic signed [SAMPLE_W-1:0] w_ext;
  logic signed [SAMPLE_W-1:0] amp;
  logic signed [SAMPLE_W-1:0] scaled;

  assign silent = note_is_silent(note);

  // A silent note parks the phase at zero so it restarts cleanly when re-enabled.
  always_comb begin
    phase_d = silent ? '0 : phase_q + PHASE_W'(note_tuning(note));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  always_comb begin
    p    = phase_q[PHASE_W-1 -: 16];
    fold = p[15] ? ~p[14:0] : p[14:0];
    case (wave_e'(wave))
      WAVE_SAW: w = p ^ 16'h8000;
      WAVE_TRI: w = ({1'b0, fold} - 16'd16384) << 1;
      default:  w = p[15] ? 16'h8000 : 16'h7FFF;
    endcase
    w_ext  = {{(SAMPLE_W-16){w[15]}}, w};
    amp    = w_ext <<< AMP_SHIFT;
    scaled = amp >>> gain;
    sample = silent ? '0 : scaled;
  end

endmodule

// File: rtl/poly_tone_mixer.sv
// Polyphonic DDS tone mixer: read a mic sample, add NUM_VOICES tones, saturate, write.
module poly_tone_mixer
  import poly_tone_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 32,
  parameter int PHASE_W    = 32,
  parameter int AMP_SHIFT  = 8
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic [4*NUM_VOICES-1:0] voice_note,
  input  logic [2*NUM_VOICES-1:0] voice_wave,
  input  logic [3*NUM_VOICES-1:0] voice_gain,
  input  logic                    mic_en,
  input  logic                    audio_in_available,
  input  logic                    audio_out_allowed,
  input  logic [SAMPLE_W-1:0]     left_channel_audio_in,
  input  logic [SAMPLE_W-1:0]     right_channel_audio_in,
  output logic                    read_audio_in,
  output logic                    write_audio_out,
  output logic [SAMPLE_W-1:0]     left_channel_audio_out,
  output logic [SAMPLE_W-1:0]     right_channel_audio_out
);

  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  logic [SAMPLE_W-1:0] voice_sample [NUM_VOICES];

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    tone_voice #(
      .SAMPLE_W  (SAMPLE_W),
      .PHASE_W   (PHASE_W),
      .AMP_SHIFT (AMP_SHIFT)
    ) u_voice (
      .clk    (CLOCK_50),
      .rst_n  (resetn),
      .note   (voice_note[4*v +: 4]),
      .wave   (voice_wave[2*v +: 2]),
      .gain   (voice_gain[3*v +: 3]),
      .sample (voice_sample[v])
    );
  end

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SAMPLE_W-1:0] snap_q [NUM_VOICES];
  logic [SAMPLE_W-1:0] snap_d [NUM_VOICES];
  logic [ACC_W-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic                read_q, read_d, write_q, write_d;
  logic [SAMPLE_W-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic [SAMPLE_W-1:0] mix_voice;
  logic [SAMPLE_W-1:0] sat_l, sat_r;

  function automatic logic [ACC_W-1:0] sext_acc(input logic [SAMPLE_W-1:0] s);
    return {{(ACC_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

  function automatic logic [63:0] sext_64(input logic [ACC_W-1:0] a);
    return {{(64-ACC_W){a[ACC_W-1]}}, a};
  endfunction

  // Handshake: read_audio_in and write_audio_out are single-cycle strobes; a read is
  // taken only in IDLE when input is available and output has room, and its paired
  // write is held in WRITE until audio_out_allowed, so strobes never overlap.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    read_d    = 1'b0;
    write_d   = 1'b0;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    mix_voice = snap_q[idx_q];
    sat_l     = SAMPLE_W'(saturate(sext_64(acc_l_q), SAMPLE_W));
    sat_r     = SAMPLE_W'(saturate(sext_64(acc_r_q), SAMPLE_W));
    case (state_q)
      ST_IDLE: begin
        if (audio_in_available && audio_out_allowed) begin
          read_d  = 1'b1;
          acc_l_d = mic_en ? sext_acc(left_channel_audio_in)  : '0;
          acc_r_d = mic_en ? sext_acc(right_channel_audio_in) : '0;
          snap_d  = voice_sample;
          idx_d   = '0;
          state_d = ST_MIX;
        end
      end
      ST_MIX: begin
        acc_l_d = acc_l_q + sext_acc(mix_voice);
        acc_r_d = acc_r_q + sext_acc(mix_voice);
        if (idx_q == LAST_IDX) state_d = ST_SAT;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      ST_SAT: begin
        out_l_d = sat_l;
        out_r_d = sat_r;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (audio_out_allowed) begin
          write_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      for (int v = 0; v < NUM_VOICES; v++) snap_q[v] <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      out_l_q <= '0;
      out_r_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      read_q  <= read_d;
      write_q <= write_d;
      out_l_q <= out_l_d;
      out_r_q <= out_r_d;
    end
  end

  assign read_audio_in           = read_q;
  assign write_audio_out         = write_q;
  assign left_channel_audio_out  = out_l_q;
  assign right_channel_audio_out = out_r_q;

endmodule
